// File: rtl/fp51_int_scheduler.sv
// fp51_int_scheduler: two-level (high/low) 8051-style interrupt arbiter.
// Latches request pulses, picks a winner from IE/IP state and offers its
// vector to the CPU through a valid/accept handshake. It tracks up to two
// nested ISRs (one low, one high) until RETI.
// Optional feature macro: INT_SCHED_OVERRUN_EN adds sticky lost-event flags.
// Without the macro, overrun is tied low and overrun_clr is ignored.
module fp51_int_scheduler #(
   parameter int          NUM_OF_INT    = 7,
   parameter int          PC_BITWIDTH   = 16,
   parameter int unsigned VECTOR_BASE   = 16'h0003,
   parameter int unsigned VECTOR_STRIDE = 8
) (
   input  logic                          clk,
   input  logic                          sync_reset,
   input  logic [NUM_OF_INT-1:0]         int_req,
   input  logic                          ie_global,
   input  logic [NUM_OF_INT-1:0]         ie_mask,
   input  logic [NUM_OF_INT-1:0]         ip_high,
   input  logic                          cpu_int_ready,
   input  logic                          int_accept,
   input  logic                          reti,
   output logic                          int_valid,
   output logic [$clog2(NUM_OF_INT)-1:0] int_id,
   output logic [PC_BITWIDTH-1:0]        int_vector,
   output logic [NUM_OF_INT-1:0]         pending,
   output logic                          in_service_hi,
   output logic                          in_service_lo,
   output logic [NUM_OF_INT-1:0]         overrun,
   input  logic                          overrun_clr
);

   localparam int ID_W = $clog2(NUM_OF_INT);

   typedef enum logic {
      S_IDLE,
      S_OFFER
   } state_t;

   state_t                state;
   logic                  offer_hi;
   logic [NUM_OF_INT-1:0] eligible;
   logic [NUM_OF_INT-1:0] hi_elig;
   logic [NUM_OF_INT-1:0] lo_elig;
   logic                  cand_found;
   logic                  cand_hi;
   logic [ID_W-1:0]       cand_id;
   logic                  accept_now;
   logic [NUM_OF_INT-1:0] acc_mask;
   logic                  svc_hi_nxt;
   logic                  svc_lo_nxt;

   // Vector address of a source; wraps silently in PC_BITWIDTH bits.
   function automatic logic [PC_BITWIDTH-1:0] vec_of(input logic [ID_W-1:0] id);
      logic [PC_BITWIDTH-1:0] base_v;
      logic [PC_BITWIDTH-1:0] id_v;
      logic [PC_BITWIDTH-1:0] stride_v;
      base_v   = PC_BITWIDTH'(VECTOR_BASE);
      id_v     = PC_BITWIDTH'(id);
      stride_v = PC_BITWIDTH'(VECTOR_STRIDE);
      return base_v + id_v * stride_v;
   endfunction

   assign eligible   = pending & ie_mask & {NUM_OF_INT{ie_global}};
   assign hi_elig    = eligible & ip_high;
   assign lo_elig    = eligible & ~ip_high;
   assign accept_now = (state == S_OFFER) && int_accept;
   assign acc_mask   = accept_now ? (NUM_OF_INT'(1) << int_id) : '0;

   // Candidate pick: lowest index wins; a running high ISR blocks everything,
   // a running low ISR blocks only other low-level sources.
   always_comb begin
      cand_found = 1'b0;
      cand_hi    = 1'b0;
      cand_id    = '0;
      if (!in_service_hi) begin
         for (int i = NUM_OF_INT - 1; i >= 0; i--) begin
            if (hi_elig[i]) begin
               cand_found = 1'b1;
               cand_hi    = 1'b1;
               cand_id    = ID_W'(i);
            end
         end
      end
      if (!cand_found && !in_service_hi && !in_service_lo) begin
         for (int i = NUM_OF_INT - 1; i >= 0; i--) begin
            if (lo_elig[i]) begin
               cand_found = 1'b1;
               cand_id    = ID_W'(i);
            end
         end
      end
   end

   // Offer FSM: register the winner, hold it stable until accept or withdrawal.
   always_ff @(posedge clk) begin
      if (sync_reset) begin
         state      <= S_IDLE;
         int_valid  <= 1'b0;
         int_id     <= '0;
         int_vector <= '0;
         offer_hi   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cpu_int_ready && cand_found) begin
                  state      <= S_OFFER;
                  int_valid  <= 1'b1;
                  int_id     <= cand_id;
                  int_vector <= vec_of(cand_id);
                  offer_hi   <= cand_hi;
               end
            end
            S_OFFER: begin
               // Accept has precedence; otherwise drop the offer once the held
               // source loses eligibility (mask or EA cleared).
               if (int_accept || !eligible[int_id]) begin
                  state     <= S_IDLE;
                  int_valid <= 1'b0;
               end
            end
            default: begin
               state     <= S_IDLE;
               int_valid <= 1'b0;
            end
         endcase
      end
   end

   // Request latch: new pulses set, an accept clears, a coincident pulse re-arms.
   always_ff @(posedge clk) begin
      if (sync_reset) begin
         pending <= '0;
      end else begin
         pending <= (pending & ~acc_mask) | int_req;
      end
   end

   // Nesting levels: RETI retires the innermost level before an accept adds one.
   always_comb begin
      svc_hi_nxt = in_service_hi;
      svc_lo_nxt = in_service_lo;
      if (reti) begin
         if (svc_hi_nxt) begin
            svc_hi_nxt = 1'b0;
         end else begin
            svc_lo_nxt = 1'b0;
         end
      end
      if (accept_now) begin
         if (offer_hi) begin
            svc_hi_nxt = 1'b1;
         end else begin
            svc_lo_nxt = 1'b1;
         end
      end
   end

   // In-service level registers.
   always_ff @(posedge clk) begin
      if (sync_reset) begin
         in_service_hi <= 1'b0;
         in_service_lo <= 1'b0;
      end else begin
         in_service_hi <= svc_hi_nxt;
         in_service_lo <= svc_lo_nxt;
      end
   end

`ifdef INT_SCHED_OVERRUN_EN
   // Sticky lost-event flags: a pulse onto a still-pending, un-accepted source;
   // a new event beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (sync_reset) begin
         overrun <= '0;
      end else begin
         overrun <= (overrun_clr ? '0 : overrun) | (int_req & pending & ~acc_mask);
      end
   end
`else
   logic unused_overrun_clr;
   assign unused_overrun_clr = overrun_clr;
   assign overrun            = '0;
`endif

endmodule

// File: tb/tb_fp51_int_scheduler.sv
// Directed testbench for fp51_int_scheduler (default parameters).
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_fp51_int_scheduler;

   logic       clk = 1'b0;
   logic       sync_reset;
   logic [6:0] int_req;
   logic       ie_global;
   logic [6:0] ie_mask;
   logic [6:0] ip_high;
   logic       cpu_int_ready;
   logic       int_accept;
   logic       reti;
   logic       int_valid;
   logic [2:0] int_id;
   logic [15:0] int_vector;
   logic [6:0] pending;
   logic       in_service_hi;
   logic       in_service_lo;
   logic [6:0] overrun;
   logic       overrun_clr;

   int checks   = 0;
   int failures = 0;

   fp51_int_scheduler dut (
      .clk           (clk),
      .sync_reset    (sync_reset),
      .int_req       (int_req),
      .ie_global     (ie_global),
      .ie_mask       (ie_mask),
      .ip_high       (ip_high),
      .cpu_int_ready (cpu_int_ready),
      .int_accept    (int_accept),
      .reti          (reti),
      .int_valid     (int_valid),
      .int_id        (int_id),
      .int_vector    (int_vector),
      .pending       (pending),
      .in_service_hi (in_service_hi),
      .in_service_lo (in_service_lo),
      .overrun       (overrun),
      .overrun_clr   (overrun_clr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      sync_reset = 1'b1;
      tick();
      tick();
      checks++; if (int_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", int_valid); end
      checks++; if (int_id !== 3'd0) begin failures++; $display("FAIL rst_id got=%0h exp=0", int_id); end
      checks++; if (int_vector !== 16'h0000) begin failures++; $display("FAIL rst_vector got=%0h exp=0", int_vector); end
      checks++; if (pending !== 7'h00) begin failures++; $display("FAIL rst_pending got=%0h exp=0", pending); end
      checks++; if ({in_service_hi, in_service_lo} !== 2'b00) begin failures++; $display("FAIL rst_in_service got=%0b exp=00", {in_service_hi, in_service_lo}); end
      checks++; if (overrun !== 7'h00) begin failures++; $display("FAIL rst_overrun got=%0h exp=0", overrun); end
      sync_reset    = 1'b0;
      ie_global     = 1'b1;
      ie_mask       = 7'h7F;
      ip_high       = 7'h00;
      cpu_int_ready = 1'b1;
   endtask

   task automatic test_basic();
      int_req = 7'h04;
      tick();
      int_req = 7'h00;
      checks++; if (pending !== 7'h04) begin failures++; $display("FAIL basic_pending got=%0h exp=04", pending); end
      checks++; if (int_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_early got=%0h exp=0", int_valid); end
      tick();
      checks++; if (int_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0h exp=1", int_valid); end
      checks++; if (int_id !== 3'd2) begin failures++; $display("FAIL basic_id got=%0h exp=2", int_id); end
      checks++; if (int_vector !== 16'h0013) begin failures++; $display("FAIL basic_vector got=%0h exp=13", int_vector); end
      int_accept = 1'b1;
      tick();
      int_accept = 1'b0;
      checks++; if (int_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_drop got=%0h exp=0", int_valid); end
      checks++; if (pending !== 7'h00) begin failures++; $display("FAIL basic_pending_clr got=%0h exp=0", pending); end
      checks++; if ({in_service_hi, in_service_lo} !== 2'b01) begin failures++; $display("FAIL basic_in_service got=%0b exp=01", {in_service_hi, in_service_lo}); end
      reti = 1'b1;
      tick();
      reti = 1'b0;
      checks++; if (in_service_lo !== 1'b0) begin failures++; $display("FAIL basic_reti got=%0h exp=0", in_service_lo); end
      // Accept coinciding with a new pulse of the same source keeps it pending.
      int_req = 7'h04;
      tick();
      int_req = 7'h00;
      tick();
      checks++; if (int_valid !== 1'b1 || int_id !== 3'd2) begin failures++; $display("FAIL rearm_offer got=%0h/%0h exp=1/2", int_valid, int_id); end
      int_accept = 1'b1;
      int_req    = 7'h04;
      tick();
      int_accept = 1'b0;
      int_req    = 7'h00;
      checks++; if (pending !== 7'h04) begin failures++; $display("FAIL rearm_pending got=%0h exp=04", pending); end
      checks++; if (in_service_lo !== 1'b1) begin failures++; $display("FAIL rearm_lo got=%0h exp=1", in_service_lo); end
      tick();
      checks++; if (int_valid !== 1'b0) begin failures++; $display("FAIL low_blocks_low got=%0h exp=0", int_valid); end
      reti = 1'b1;
      tick();
      reti = 1'b0;
      tick();
      checks++; if (int_valid !== 1'b1 || int_id !== 3'd2) begin failures++; $display("FAIL rearm_reoffer got=%0h/%0h exp=1/2", int_valid, int_id); end
      int_accept = 1'b1;
      tick();
      int_accept = 1'b0;
      reti = 1'b1;
      tick();
      reti = 1'b0;
   endtask

   task automatic test_priority();
      ip_high = 7'h10;
      int_req = 7'h12;
      tick();
      int_req = 7'h00;
      checks++; if (pending !== 7'h12) begin failures++; $display("FAIL prio_pending got=%0h exp=12", pending); end
      tick();
      checks++; if (int_valid !== 1'b1 || int_id !== 3'd4) begin failures++; $display("FAIL prio_id got=%0h/%0h exp=1/4", int_valid, int_id); end
      checks++; if (int_vector !== 16'h0023) begin failures++; $display("FAIL prio_vector got=%0h exp=23", int_vector); end
      int_accept = 1'b1;
      tick();
      int_accept = 1'b0;
      checks++; if ({in_service_hi, in_service_lo} !== 2'b10) begin failures++; $display("FAIL prio_in_service got=%0b exp=10", {in_service_hi, in_service_lo}); end
      checks++; if (pending !== 7'h02) begin failures++; $display("FAIL prio_pending_left got=%0h exp=02", pending); end
      reti = 1'b1;
      tick();
      reti = 1'b0;
      checks++; if (int_valid !== 1'b0 || in_service_hi !== 1'b0) begin failures++; $display("FAIL prio_reti got=%0h/%0h exp=0/0", int_valid, in_service_hi); end
      tick();
      checks++; if (int_valid !== 1'b1 || int_id !== 3'd1) begin failures++; $display("FAIL prio_second_id got=%0h/%0h exp=1/1", int_valid, int_id); end
      checks++; if (int_vector !== 16'h000B) begin failures++; $display("FAIL prio_second_vector got=%0h exp=0b", int_vector); end
      int_accept = 1'b1;
      tick();
      int_accept = 1'b0;
      checks++; if ({in_service_hi, in_service_lo} !== 2'b01) begin failures++; $display("FAIL prio_second_lo got=%0b exp=01", {in_service_hi, in_service_lo}); end
      reti = 1'b1;
      tick();
      reti = 1'b0;
      ip_high = 7'h00;
   endtask

   task automatic test_nesting();
      int_req = 7'h08;
      tick();
      int_req = 7'h00;
      tick();
      checks++; if (int_valid !== 1'b1 || int_id !== 3'd3) begin failures++; $display("FAIL nest_low_id got=%0h/%0h exp=1/3", int_valid, int_id); end
      int_accept = 1'b1;
      tick();
      int_accept = 1'b0;
      ip_high = 7'h01;
      int_req = 7'h01;
      tick();
      int_req = 7'h00;
      tick();
      checks++; if (int_valid !== 1'b1 || int_id !== 3'd0) begin failures++; $display("FAIL nest_preempt_id got=%0h/%0h exp=1/0", int_valid, int_id); end
      checks++; if (int_vector !== 16'h0003) begin failures++; $display("FAIL nest_preempt_vector got=%0h exp=03", int_vector); end
      int_accept = 1'b1;
      tick();
      int_accept = 1'b0;
      checks++; if ({in_service_hi, in_service_lo} !== 2'b11) begin failures++; $display("FAIL nest_both got=%0b exp=11", {in_service_hi, in_service_lo}); end
      reti = 1'b1;
      tick();
      checks++; if ({in_service_hi, in_service_lo} !== 2'b01) begin failures++; $display("FAIL nest_reti1 got=%0b exp=01", {in_service_hi, in_service_lo}); end
      tick();
      reti = 1'b0;
      checks++; if ({in_service_hi, in_service_lo} !== 2'b00) begin failures++; $display("FAIL nest_reti2 got=%0b exp=00", {in_service_hi, in_service_lo}); end
      // RETI and accept together: the low level retires, then the high level is entered.
      int_req = 7'h08;
      tick();
      int_req = 7'h00;
      tick();
      int_accept = 1'b1;
      tick();
      int_accept = 1'b0;
      int_req = 7'h01;
      tick();
      int_req = 7'h00;
      tick();
      checks++; if (int_valid !== 1'b1 || int_id !== 3'd0) begin failures++; $display("FAIL order_offer got=%0h/%0h exp=1/0", int_valid, int_id); end
      int_accept = 1'b1;
      reti       = 1'b1;
      tick();
      int_accept = 1'b0;
      reti       = 1'b0;
      checks++; if ({in_service_hi, in_service_lo} !== 2'b10) begin failures++; $display("FAIL order_reti_accept got=%0b exp=10", {in_service_hi, in_service_lo}); end
      reti = 1'b1;
      tick();
      reti = 1'b0;
      ip_high = 7'h00;
   endtask

   task automatic test_withdraw();
      int_req = 7'h20;
      tick();
      int_req = 7'h00;
      tick();
      checks++; if (int_valid !== 1'b1 || int_id !== 3'd5) begin failures++; $display("FAIL wd_offer got=%0h/%0h exp=1/5", int_valid, int_id); end
      checks++; if (int_vector !== 16'h002B) begin failures++; $display("FAIL wd_vector got=%0h exp=2b", int_vector); end
      ie_global = 1'b0;
      tick();
      checks++; if (int_valid !== 1'b0) begin failures++; $display("FAIL wd_valid got=%0h exp=0", int_valid); end
      checks++; if (pending !== 7'h20) begin failures++; $display("FAIL wd_pending got=%0h exp=20", pending); end
      ie_global = 1'b1;
      tick();
      checks++; if (int_valid !== 1'b1 || int_id !== 3'd5) begin failures++; $display("FAIL wd_reoffer got=%0h/%0h exp=1/5", int_valid, int_id); end
      int_accept = 1'b1;
      tick();
      int_accept = 1'b0;
      reti = 1'b1;
      tick();
      reti = 1'b0;
      // No offer while the CPU is not at an instruction boundary.
      cpu_int_ready = 1'b0;
      int_req = 7'h02;
      tick();
      int_req = 7'h00;
      tick();
      checks++; if (int_valid !== 1'b0) begin failures++; $display("FAIL ready_gate got=%0h exp=0", int_valid); end
      cpu_int_ready = 1'b1;
      tick();
      checks++; if (int_valid !== 1'b1 || int_id !== 3'd1) begin failures++; $display("FAIL ready_offer got=%0h/%0h exp=1/1", int_valid, int_id); end
      int_accept = 1'b1;
      tick();
      int_accept = 1'b0;
      reti = 1'b1;
      tick();
      reti = 1'b0;
   endtask

   task automatic test_reset_mid();
      int_req = 7'h40;
      tick();
      int_req = 7'h00;
      tick();
      checks++; if (int_valid !== 1'b1 || int_id !== 3'd6) begin failures++; $display("FAIL rmid_offer got=%0h/%0h exp=1/6", int_valid, int_id); end
      sync_reset = 1'b1;
      int_accept = 1'b1;
      tick();
      sync_reset = 1'b0;
      int_accept = 1'b0;
      checks++; if (int_valid !== 1'b0 || int_id !== 3'd0 || int_vector !== 16'h0) begin failures++; $display("FAIL rmid_offer_clr got=%0h/%0h/%0h exp=0/0/0", int_valid, int_id, int_vector); end
      checks++; if (pending !== 7'h00 || {in_service_hi, in_service_lo} !== 2'b00) begin failures++; $display("FAIL rmid_state got=%0h/%0b exp=0/00", pending, {in_service_hi, in_service_lo}); end
      int_req = 7'h02;
      tick();
      int_req = 7'h00;
      tick();
      checks++; if (int_valid !== 1'b1 || int_id !== 3'd1 || int_vector !== 16'h000B) begin failures++; $display("FAIL rmid_after got=%0h/%0h/%0h exp=1/1/b", int_valid, int_id, int_vector); end
      int_accept = 1'b1;
      tick();
      int_accept = 1'b0;
      reti = 1'b1;
      tick();
      reti = 1'b0;
   endtask

   task automatic test_overrun();
      logic [6:0] exp_ovr;
`ifdef INT_SCHED_OVERRUN_EN
      exp_ovr = 7'h40;
`else
      exp_ovr = 7'h00;
`endif
      ie_mask = 7'h3F;
      int_req = 7'h40;
      tick();
      int_req = 7'h00;
      tick();
      int_req = 7'h40;
      tick();
      int_req = 7'h00;
      checks++; if (overrun !== exp_ovr) begin failures++; $display("FAIL ovr_set got=%0h exp=%0h", overrun, exp_ovr); end
      checks++; if (int_valid !== 1'b0) begin failures++; $display("FAIL ovr_masked got=%0h exp=0", int_valid); end
      overrun_clr = 1'b1;
      tick();
      overrun_clr = 1'b0;
      checks++; if (overrun !== 7'h00) begin failures++; $display("FAIL ovr_clr got=%0h exp=0", overrun); end
      overrun_clr = 1'b1;
      int_req     = 7'h40;
      tick();
      overrun_clr = 1'b0;
      int_req     = 7'h00;
      checks++; if (overrun !== exp_ovr) begin failures++; $display("FAIL ovr_set_wins got=%0h exp=%0h", overrun, exp_ovr); end
      ie_mask = 7'h7F;
      tick();
      checks++; if (int_valid !== 1'b1 || int_vector !== 16'h0033) begin failures++; $display("FAIL ovr_unmask got=%0h/%0h exp=1/33", int_valid, int_vector); end
      int_accept = 1'b1;
      tick();
      int_accept = 1'b0;
      reti = 1'b1;
      tick();
      reti = 1'b0;
   endtask

   initial begin
      sync_reset    = 1'b1;
      int_req       = '0;
      ie_global     = 1'b0;
      ie_mask       = '0;
      ip_high       = '0;
      cpu_int_ready = 1'b0;
      int_accept    = 1'b0;
      reti          = 1'b0;
      overrun_clr   = 1'b0;
      test_reset();
      test_basic();
      test_priority();
      test_nesting();
      test_withdraw();
      test_reset_mid();
      test_overrun();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
